// File: rtl/pwr_seq_ctrl.sv
// Rail power sequencer: brings NumRails supplies up in ascending order on request,
// removes them in descending order on release, and latches a fault on PG loss or timeout.
module pwr_seq_ctrl #(
    parameter int                  NumRails    = 4,
    parameter int                  CntWidth    = 8,
    parameter logic [CntWidth-1:0] DlyMs       = CntWidth'(10),
    parameter logic [CntWidth-1:0] PgTimeoutMs = CntWidth'(50),
    parameter logic [CntWidth-1:0] OffDlyMs    = CntWidth'(5)
) (
    input  logic                CLK_IN,
    input  logic                RESET_N,
    input  logic                TICK_1MS,
    input  logic                PWR_ON_REQ,
    input  logic [NumRails-1:0] PG_IN,
    output logic [NumRails-1:0] RAIL_EN_O,
    output logic                PWR_OK_O,
    output logic                FAULT_O,
    output logic [NumRails-1:0] FAULT_RAIL_O,
    output logic [2:0]          STATE_O
);
    localparam int IdxW = (NumRails > 1) ? $clog2(NumRails) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ON_DLY  = 3'd1;
    localparam logic [2:0] S_WAIT_PG = 3'd2;
    localparam logic [2:0] S_ON      = 3'd3;
    localparam logic [2:0] S_OFF_DLY = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [CntWidth-1:0] DlyLast = DlyMs - 1'b1;
    localparam logic [CntWidth-1:0] PgLast  = PgTimeoutMs - 1'b1;
    localparam logic [CntWidth-1:0] OffLast = OffDlyMs - 1'b1;
    localparam logic [IdxW-1:0]     IdxLast = IdxW'(NumRails - 1);

    logic [1:0]          req_sync_q;
    logic [NumRails-1:0] pg_sync1_q, pg_s_q;
    logic                req_s;

    logic [2:0]          state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [NumRails-1:0] rail_en_q, rail_en_d;
    logic [NumRails-1:0] conf_q, conf_d;
    logic                fault_q, fault_d;
    logic [NumRails-1:0] fault_rail_q, fault_rail_d;
    logic                pwr_ok_q;

    logic                restart;
    logic [NumRails-1:0] drop;
    logic [NumRails-1:0] en_shed;
    logic                found;

    assign req_s = req_sync_q[1];
    // Rails that were confirmed good while enabled and have since lost power-good.
    assign drop  = rail_en_q & conf_q & ~pg_s_q;

    always_comb begin
        en_shed = rail_en_q;
        found   = 1'b0;
        for (int i = NumRails - 1; i >= 0; i--) begin
            if (!found && rail_en_q[i]) begin
                en_shed[i] = 1'b0;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rail_en_d    = rail_en_q;
        conf_d       = conf_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        restart      = 1'b0;
        case (state_q)
            S_IDLE: begin
                rail_en_d = '0;
                conf_d    = '0;
                if (req_s) begin
                    state_d = S_ON_DLY;
                    idx_d   = '0;
                end
            end
            S_ON_DLY, S_WAIT_PG, S_ON: begin
                if (|drop) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_rail_d = drop;
                    rail_en_d    = '0;
                    conf_d       = '0;
                end else if (!req_s) begin
                    state_d = S_OFF_DLY;
                end else if (state_q == S_ON_DLY) begin
                    if (TICK_1MS && cnt_q == DlyLast) begin
                        rail_en_d[idx_q] = 1'b1;
                        state_d          = S_WAIT_PG;
                    end
                end else if (state_q == S_WAIT_PG) begin
                    // Power-good is checked first so it wins a same-cycle race with timeout.
                    if (pg_s_q[idx_q]) begin
                        conf_d[idx_q] = 1'b1;
                        if (idx_q == IdxLast) begin
                            state_d = S_ON;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_ON_DLY;
                        end
                    end else if (TICK_1MS && cnt_q == PgLast) begin
                        state_d             = S_FAULT;
                        fault_d             = 1'b1;
                        fault_rail_d        = '0;
                        fault_rail_d[idx_q] = 1'b1;
                        rail_en_d           = '0;
                        conf_d              = '0;
                    end
                end
            end
            S_OFF_DLY: begin
                if (rail_en_q == '0) begin
                    state_d = S_IDLE;
                end else if (TICK_1MS && cnt_q == OffLast) begin
                    rail_en_d = en_shed;
                    conf_d    = conf_q & en_shed;
                    restart   = 1'b1;
                    if (en_shed == '0) state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                rail_en_d = '0;
                conf_d    = '0;
                fault_d   = 1'b1;
                if (!req_s) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b0;
                    fault_rail_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rail_en_d = '0;
                conf_d    = '0;
            end
        endcase
        if (state_d != state_q || restart) begin
            cnt_d = '0;
        end else if (TICK_1MS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            req_sync_q   <= '0;
            pg_sync1_q   <= '0;
            pg_s_q       <= '0;
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            conf_q       <= '0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
            pwr_ok_q     <= 1'b0;
        end else begin
            req_sync_q   <= {req_sync_q[0], PWR_ON_REQ};
            pg_sync1_q   <= PG_IN;
            pg_s_q       <= pg_sync1_q;
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rail_en_q    <= rail_en_d;
            conf_q       <= conf_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
            pwr_ok_q     <= (state_d == S_ON);
        end
    end

    assign RAIL_EN_O    = rail_en_q;
    assign PWR_OK_O     = pwr_ok_q;
    assign FAULT_O      = fault_q;
    assign FAULT_RAIL_O = fault_rail_q;
    assign STATE_O      = state_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: power-up, release, PG race, reset, runtime drop,
// PG timeout, tick gating and empty shutdown, with hand-computed edge counts.
`timescale 1ns/1ps
module tb_pwr_seq_ctrl;
    logic       CLK_IN = 1'b0;
    logic       RESET_N;
    logic       TICK_1MS;
    logic       PWR_ON_REQ;
    logic [3:0] PG_IN;
    logic [3:0] RAIL_EN_O;
    logic       PWR_OK_O;
    logic       FAULT_O;
    logic [3:0] FAULT_RAIL_O;
    logic [2:0] STATE_O;

    int compared   = 0;
    int mismatched = 0;

    pwr_seq_ctrl dut (
        .CLK_IN       (CLK_IN),
        .RESET_N      (RESET_N),
        .TICK_1MS     (TICK_1MS),
        .PWR_ON_REQ   (PWR_ON_REQ),
        .PG_IN        (PG_IN),
        .RAIL_EN_O    (RAIL_EN_O),
        .PWR_OK_O     (PWR_OK_O),
        .FAULT_O      (FAULT_O),
        .FAULT_RAIL_O (FAULT_RAIL_O),
        .STATE_O      (STATE_O)
    );

    always #250 CLK_IN = ~CLK_IN;

    task automatic step(input int n);
        repeat (n) @(negedge CLK_IN);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits out one ON_DLY (entry + 10 ticks) and checks the enable mask around the rising edge.
    task automatic power_rail(input int i, input bit set_pg);
        logic [3:0] prior;
        logic [3:0] now_m;
        prior = 4'((1 << i) - 1);
        now_m = 4'((1 << (i + 1)) - 1);
        step(12);
        chk($sformatf("en_before_%0d", i), 32'(RAIL_EN_O), 32'(prior));
        step(1);
        chk($sformatf("en_after_%0d", i), 32'(RAIL_EN_O), 32'(now_m));
        chk($sformatf("wait_pg_%0d", i), 32'(STATE_O), 32'd2);
        if (set_pg) PG_IN[i] = 1'b1;
    endtask

    initial begin
        RESET_N    = 1'b0;
        TICK_1MS   = 1'b1;
        PWR_ON_REQ = 1'b0;
        PG_IN      = 4'b0000;
        step(3);
        chk("rst_en", 32'(RAIL_EN_O), 32'h0);
        chk("rst_state", 32'(STATE_O), 32'd0);
        chk("rst_ok", 32'(PWR_OK_O), 32'd0);
        chk("rst_fault", 32'(FAULT_O), 32'd0);
        chk("rst_frail", 32'(FAULT_RAIL_O), 32'h0);
        RESET_N = 1'b1;
        step(2);
        chk("idle_state", 32'(STATE_O), 32'd0);

        // Nominal power-up
        PWR_ON_REQ = 1'b1;
        for (int i = 0; i < 4; i++) power_rail(i, 1'b1);
        step(2);
        chk("pre_on_state", 32'(STATE_O), 32'd2);
        chk("pre_on_ok", 32'(PWR_OK_O), 32'd0);
        step(1);
        chk("on_state", 32'(STATE_O), 32'd3);
        chk("on_ok", 32'(PWR_OK_O), 32'd1);
        chk("on_en", 32'(RAIL_EN_O), 32'hf);
        chk("on_fault", 32'(FAULT_O), 32'd0);

        // Release with a mid-way re-request
        PWR_ON_REQ = 1'b0;
        step(3);
        chk("rel_state", 32'(STATE_O), 32'd4);
        chk("rel_en", 32'(RAIL_EN_O), 32'hf);
        chk("rel_ok", 32'(PWR_OK_O), 32'd0);
        step(1);
        PG_IN = 4'b0000;
        step(4);
        chk("rel_en_0111", 32'(RAIL_EN_O), 32'h7);
        step(2);
        PWR_ON_REQ = 1'b1;
        step(3);
        chk("rel_en_0011", 32'(RAIL_EN_O), 32'h3);
        chk("rel_ignore_req", 32'(STATE_O), 32'd4);
        chk("rel_no_fault", 32'(FAULT_O), 32'd0);
        step(5);
        chk("rel_en_0001", 32'(RAIL_EN_O), 32'h1);
        step(5);
        chk("rel_en_0000", 32'(RAIL_EN_O), 32'h0);
        chk("rel_idle", 32'(STATE_O), 32'd0);
        step(1);
        chk("restart_on_dly", 32'(STATE_O), 32'd1);

        // PG arrives in the very cycle the timeout expires
        step(10);
        chk("race_en0", 32'(RAIL_EN_O), 32'h1);
        chk("race_wait", 32'(STATE_O), 32'd2);
        step(47);
        PG_IN[0] = 1'b1;
        step(2);
        chk("race_pre_state", 32'(STATE_O), 32'd2);
        chk("race_pre_fault", 32'(FAULT_O), 32'd0);
        step(1);
        chk("race_state", 32'(STATE_O), 32'd1);
        chk("race_fault", 32'(FAULT_O), 32'd0);
        chk("race_en", 32'(RAIL_EN_O), 32'h1);
        step(10);
        chk("race_idx1_en", 32'(RAIL_EN_O), 32'h3);
        chk("race_idx1_state", 32'(STATE_O), 32'd2);

        // Asynchronous reset during WAIT_PG for rail 1
        #100;
        RESET_N = 1'b0;
        #1;
        chk("arst_en", 32'(RAIL_EN_O), 32'h0);
        chk("arst_state", 32'(STATE_O), 32'd0);
        chk("arst_ok", 32'(PWR_OK_O), 32'd0);
        chk("arst_fault", 32'(FAULT_O), 32'd0);
        PG_IN = 4'b0000;
        step(2);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) power_rail(i, 1'b1);
        step(3);
        chk("re_on_state", 32'(STATE_O), 32'd3);
        chk("re_on_ok", 32'(PWR_OK_O), 32'd1);

        // Runtime loss of PG on rail 1
        PG_IN[1] = 1'b0;
        step(2);
        chk("drop_pre_state", 32'(STATE_O), 32'd3);
        chk("drop_pre_ok", 32'(PWR_OK_O), 32'd1);
        step(1);
        chk("drop_state", 32'(STATE_O), 32'd5);
        chk("drop_en", 32'(RAIL_EN_O), 32'h0);
        chk("drop_frail", 32'(FAULT_RAIL_O), 32'h2);
        chk("drop_fault", 32'(FAULT_O), 32'd1);
        chk("drop_ok", 32'(PWR_OK_O), 32'd0);
        step(5);
        chk("drop_hold", 32'(STATE_O), 32'd5);
        PWR_ON_REQ = 1'b0;
        PG_IN      = 4'b0000;
        step(3);
        chk("drop_clr_state", 32'(STATE_O), 32'd0);
        chk("drop_clr_fault", 32'(FAULT_O), 32'd0);
        chk("drop_clr_frail", 32'(FAULT_RAIL_O), 32'h0);

        // PG timeout on rail 2
        PWR_ON_REQ = 1'b1;
        power_rail(0, 1'b1);
        power_rail(1, 1'b1);
        power_rail(2, 1'b0);
        step(49);
        chk("to_pre_state", 32'(STATE_O), 32'd2);
        chk("to_pre_en", 32'(RAIL_EN_O), 32'h7);
        chk("to_pre_fault", 32'(FAULT_O), 32'd0);
        step(1);
        chk("to_state", 32'(STATE_O), 32'd5);
        chk("to_fault", 32'(FAULT_O), 32'd1);
        chk("to_frail", 32'(FAULT_RAIL_O), 32'h4);
        chk("to_en", 32'(RAIL_EN_O), 32'h0);
        PWR_ON_REQ = 1'b0;
        PG_IN      = 4'b0000;
        step(3);
        chk("to_clr_state", 32'(STATE_O), 32'd0);
        chk("to_clr_fault", 32'(FAULT_O), 32'd0);
        chk("to_clr_frail", 32'(FAULT_RAIL_O), 32'h0);

        // Counter advances only on TICK_1MS
        TICK_1MS   = 1'b0;
        PWR_ON_REQ = 1'b1;
        step(3);
        chk("tick_on_dly", 32'(STATE_O), 32'd1);
        step(30);
        chk("tick_hold_state", 32'(STATE_O), 32'd1);
        chk("tick_hold_en", 32'(RAIL_EN_O), 32'h0);
        for (int k = 0; k < 9; k++) begin
            TICK_1MS = 1'b1;
            step(1);
            TICK_1MS = 1'b0;
            step(1);
        end
        chk("tick_9_en", 32'(RAIL_EN_O), 32'h0);
        TICK_1MS = 1'b1;
        step(1);
        chk("tick_10_en", 32'(RAIL_EN_O), 32'h1);
        chk("tick_10_state", 32'(STATE_O), 32'd2);

        // Release from WAIT_PG with one rail enabled
        PWR_ON_REQ = 1'b0;
        step(3);
        chk("wrel_state", 32'(STATE_O), 32'd4);
        chk("wrel_en", 32'(RAIL_EN_O), 32'h1);
        step(5);
        chk("wrel_en_off", 32'(RAIL_EN_O), 32'h0);
        chk("wrel_idle", 32'(STATE_O), 32'd0);

        // Release before any rail is enabled
        PWR_ON_REQ = 1'b1;
        step(3);
        chk("empty_on_dly", 32'(STATE_O), 32'd1);
        PWR_ON_REQ = 1'b0;
        step(3);
        chk("empty_off_dly", 32'(STATE_O), 32'd4);
        chk("empty_en", 32'(RAIL_EN_O), 32'h0);
        step(1);
        chk("empty_idle", 32'(STATE_O), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
